// File: rtl/pcie_axi_pkg.sv
// Shared definitions for the PCIe RX 64-to-32 AXI-Stream down-converter.
//   - egress FSM state encoding
//   - ingress FIFO entry layout {last, keep[7:0], data[63:0]}
//   - legal keep constants and the keep legality check
//   - egress dword record used for the registered 32-bit outputs
package pcie_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_BOT = 2'd1,
    ST_SEND_TOP = 2'd2
  } egress_state_e;

  localparam int ENTRY_W  = 73;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 63;
  localparam int KEEP_LSB = 64;
  localparam int KEEP_MSB = 71;
  localparam int LAST_BIT = 72;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_LOW  = 8'h0F;

  // One egress dword as presented on the 32-bit side.
  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } dword_t;

  // A beat is legal with all bytes enabled, or with only the lower dword on the last beat.
  function automatic logic keep_illegal(input logic [7:0] keep, input logic last);
    keep_illegal = !((keep == KEEP_FULL) || ((keep == KEEP_LOW) && last));
  endfunction

endpackage

// File: rtl/pcie_axi_sync_fifo.sv
// Single-clock synchronous FIFO with show-ahead read data.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : write request, ignored while full
//   rd_en/rd_data : pop request, ignored while empty; rd_data shows the head entry
//   full, empty   : status from extended-MSB pointers
module pcie_axi_sync_fifo #(
  parameter int DATA_WIDTH    = 73,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0]  mem_r [0:(1<<ADDRESS_WIDTH)-1];
  logic [ADDRESS_WIDTH:0] wr_ptr_r;
  logic [ADDRESS_WIDTH:0] rd_ptr_r;

  // Pointers carry one extra MSB so full and empty are distinguishable when the low bits match.
  assign full    = (wr_ptr_r[ADDRESS_WIDTH] != rd_ptr_r[ADDRESS_WIDTH]) &&
                   (wr_ptr_r[ADDRESS_WIDTH-1:0] == rd_ptr_r[ADDRESS_WIDTH-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign rd_data = mem_r[rd_ptr_r[ADDRESS_WIDTH-1:0]];

  // Pointer update; a write into a full FIFO is dropped even when a pop happens the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr_r <= wr_ptr_r + (ADDRESS_WIDTH+1)'(1);
      end
      if (rd_en && !empty) begin
        rd_ptr_r <= rd_ptr_r + (ADDRESS_WIDTH+1)'(1);
      end
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem_r[wr_ptr_r[ADDRESS_WIDTH-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/pcie_64_to_32_axi.sv
// PCIe RX width down-converter: 64-bit AXI-Stream TLP beats in, 32-bit dwords out,
// lower dword [31:0] first, upper [63:32] only when keep[7:4] is non-zero.
//   clk, rst                        : clock, synchronous active-high reset
//   i_64_data/keep/valid/last       : ingress beat; o_64_ready = FIFO not full
//   o_32_data/keep/valid/last       : registered egress dword; i_32_ready from consumer
//   o_keep_err                      : sticky illegal-keep flag, cleared only by rst
//   o_pkt_count                     : accepted dwords carrying last, wraps at 16 bits
module pcie_64_to_32_axi
  import pcie_axi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_64_data,
  input  logic [7:0]  i_64_keep,
  input  logic        i_64_valid,
  input  logic        i_64_last,
  output logic        o_64_ready,
  output logic [31:0] o_32_data,
  output logic [3:0]  o_32_keep,
  output logic        o_32_valid,
  output logic        o_32_last,
  input  logic        i_32_ready,
  output logic        o_keep_err,
  output logic [15:0] o_pkt_count
);

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [ENTRY_W-1:0]   fifo_rd_data_s;
  logic                 wr_en_s;
  logic                 pop_s;
  logic                 accept_s;
  logic [7:0]           rd_keep_s;
  logic                 rd_last_s;
  dword_t               next_lower_s;

  egress_state_e        state_r;
  dword_t               out_r;
  logic                 out_valid_r;
  logic [31:0]          hold_data_hi_r;
  logic [3:0]           hold_keep_hi_r;
  logic                 hold_last_r;
  logic                 keep_err_r;
  logic [15:0]          pkt_count_r;

  assign o_64_ready = !fifo_full_s;
  assign wr_en_s    = i_64_valid && !fifo_full_s;
  assign accept_s   = out_valid_r && i_32_ready;

  assign rd_keep_s  = fifo_rd_data_s[KEEP_MSB:KEEP_LSB];
  assign rd_last_s  = fifo_rd_data_s[LAST_BIT];

  assign o_32_data   = out_r.data;
  assign o_32_keep   = out_r.keep;
  assign o_32_last   = out_r.last;
  assign o_32_valid  = out_valid_r;
  assign o_keep_err  = keep_err_r;
  assign o_pkt_count = pkt_count_r;

  pcie_axi_sync_fifo #(
    .DATA_WIDTH    (ENTRY_W),
    .ADDRESS_WIDTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data ({i_64_last, i_64_keep, i_64_data}),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Lower dword of the FIFO head; it ends the TLP only if the beat has no upper dword.
  always_comb begin
    next_lower_s      = '0;
    next_lower_s.data = fifo_rd_data_s[31:0];
    next_lower_s.keep = rd_keep_s[3:0];
    next_lower_s.last = rd_last_s && (rd_keep_s[7:4] == 4'h0);
  end

  // Pop decision: refill the output register only when it is empty or its dword is leaving
  // and nothing of the current beat remains to be sent.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) pop_s = 1'b1;
        else               pop_s = 1'b0;
      end
      ST_SEND_BOT: begin
        if (accept_s && (hold_keep_hi_r == 4'h0) && !fifo_empty_s) pop_s = 1'b1;
        else                                                       pop_s = 1'b0;
      end
      ST_SEND_TOP: begin
        if (accept_s && !fifo_empty_s) pop_s = 1'b1;
        else                           pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // Egress FSM with hold register and registered 32-bit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      out_r          <= '0;
      out_valid_r    <= 1'b0;
      hold_data_hi_r <= 32'h0;
      hold_keep_hi_r <= 4'h0;
      hold_last_r    <= 1'b0;
    end else if (pop_s) begin
      state_r        <= ST_SEND_BOT;
      out_r          <= next_lower_s;
      out_valid_r    <= 1'b1;
      hold_data_hi_r <= fifo_rd_data_s[DATA_MSB:32];
      hold_keep_hi_r <= rd_keep_s[7:4];
      hold_last_r    <= rd_last_s;
    end else begin
      case (state_r)
        ST_SEND_BOT: begin
          if (accept_s && (hold_keep_hi_r != 4'h0)) begin
            state_r    <= ST_SEND_TOP;
            out_r.data <= hold_data_hi_r;
            out_r.keep <= hold_keep_hi_r;
            out_r.last <= hold_last_r;
          end else if (accept_s) begin
            // FIFO empty: drop valid so the sent dword is never repeated.
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_r.last  <= 1'b0;
          end
        end
        ST_SEND_TOP: begin
          if (accept_s) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_r.last  <= 1'b0;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag for illegal keep patterns, evaluated on every written beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      keep_err_r <= 1'b0;
    end else if (wr_en_s && keep_illegal(i_64_keep, i_64_last)) begin
      keep_err_r <= 1'b1;
    end
  end

  // Completed-TLP counter on accepted last dwords; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_r <= 16'h0;
    end else if (accept_s && out_r.last) begin
      pkt_count_r <= pkt_count_r + 16'h1;
    end
  end

endmodule
